// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl
// Single-outstanding load/store responder in front of a dual-port data RAM
// that has no byte enables. Word stores write directly. Byte and half stores
// read the word, merge the new lane(s) and write the word back. Loads read
// the word and extract the lane, then zero- or sign-extend it. Addresses are
// little-endian and the data path is 32 bits wide.
//
// Ports
//   clk, rst          : single rising-edge clock, synchronous active-high reset
//   req_valid/ready   : request handshake, transfer when both are high (cycle T)
//   req_we            : 1 = store, 0 = load
//   req_addr          : byte address (ADDR_WIDTH+2 bits)
//   req_size          : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      : loads only, 1 = zero-extend, 0 = sign-extend
//   req_wdata         : store data, right-aligned
//   rsp_valid         : one-cycle completion pulse
//   rsp_err           : misaligned or reserved access (qualified by rsp_valid)
//   rsp_rdata         : extended load data, 0 for stores and errors
//   ram_raddr         : RAM read word address
//   ram_waddr/we/din  : RAM write port
//   ram_dout          : RAM read data, valid RAM_RD_LAT cycles after ram_raddr
module ram_rmw_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Count value of the cycle in which ram_dout holds the requested word.
  localparam logic [1:0] LAT_LAST = 2'(RAM_RD_LAT - 1);

  state_t                  state_r;
  logic [1:0]              lat_cnt_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   word_r;
  logic [1:0]              off_r;
  logic [1:0]              size_r;
  logic                    uns_r;
  logic [31:0]             wdata_r;
  logic                    rsp_valid_r;
  logic                    rsp_err_r;
  logic [31:0]             rsp_rdata_r;
  logic                    ram_we_r;
  logic [ADDR_WIDTH-1:0]   ram_waddr_r;
  logic [31:0]             ram_din_r;
  logic                    req_err_s;

  // 1 when the access is misaligned for its size or uses the reserved size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    e = 1'b0;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = off[0];
      2'b10:   e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Select the addressed lane of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'd0;
    h = 16'd0;
    r = 32'd0;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r = {word[31:8], wd[7:0]};
          2'b01:   r = {word[31:16], wd[7:0], word[7:0]};
          2'b10:   r = {word[31:24], wd[7:0], word[15:0]};
          default: r = {wd[7:0], word[23:0]};
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          r = {wd[15:0], word[15:0]};
        end else begin
          r = {word[31:16], wd[15:0]};
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_err_s = access_err(req_size, req_addr[1:0]);
  assign req_ready = (state_r == IDLE) && !rst;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign ram_we    = ram_we_r;
  assign ram_waddr = ram_waddr_r;
  assign ram_din   = ram_din_r;

  // Read address: live request address while idle so the read starts in T.
  always_comb begin
    ram_raddr = word_r;
    if (state_r == IDLE) begin
      ram_raddr = req_addr[ADDR_WIDTH+1:2];
    end else begin
      ram_raddr = word_r;
    end
  end

  // Request sequencer: capture at T, wait for read data, write back, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      lat_cnt_r   <= 2'd0;
      we_r        <= 1'b0;
      word_r      <= '0;
      off_r       <= 2'd0;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      wdata_r     <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
      ram_we_r    <= 1'b0;
      ram_waddr_r <= '0;
      ram_din_r   <= 32'd0;
    end else begin
      // Response and write strobes are single-cycle pulses.
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      ram_we_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r      <= req_we;
            word_r    <= req_addr[ADDR_WIDTH+1:2];
            off_r     <= req_addr[1:0];
            size_r    <= req_size;
            uns_r     <= req_unsigned;
            wdata_r   <= req_wdata;
            lat_cnt_r <= 2'd0;
            if (req_err_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'd0;
              state_r     <= DONE;
            end else if (req_we && (req_size == 2'b10)) begin
              // Full-word store needs no read.
              ram_we_r    <= 1'b1;
              ram_waddr_r <= req_addr[ADDR_WIDTH+1:2];
              ram_din_r   <= req_wdata;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= 32'd0;
              state_r     <= DONE;
            end else begin
              state_r <= RD_WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
            if (we_r) begin
              ram_we_r    <= 1'b1;
              ram_waddr_r <= word_r;
              ram_din_r   <= store_merge(ram_dout, wdata_r, size_r, off_r);
              rsp_rdata_r <= 32'd0;
            end else begin
              rsp_rdata_r <= load_extend(ram_dout, size_r, off_r, uns_r);
            end
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Bench for ram_rmw_ctrl: two instances (read latency 1 and 2), each with its
// own RAM model and a transaction-level reference model checked every cycle.
module tb_ram_rmw_ctrl;
  logic        clk;
  logic        rst;
  logic        vld;
  int          sel;
  logic        we;
  logic [11:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wd;

  logic        v_in [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic        re   [2];
  logic        rwe  [2];
  logic [31:0] rdat [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic [9:0]  ra   [2];
  logic [9:0]  wa   [2];

  assign v_in[0] = vld && (sel == 0);
  assign v_in[1] = vld && (sel == 1);

  ram_rmw_ctrl #(.ADDR_WIDTH(10), .RAM_RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v_in[0]), .req_ready(rdy[0]), .req_we(we),
    .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wd),
    .rsp_valid(rv[0]), .rsp_err(re[0]), .rsp_rdata(rdat[0]), .ram_raddr(ra[0]),
    .ram_waddr(wa[0]), .ram_we(rwe[0]), .ram_din(din[0]), .ram_dout(dout[0]));

  ram_rmw_ctrl #(.ADDR_WIDTH(10), .RAM_RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v_in[1]), .req_ready(rdy[1]), .req_we(we),
    .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wd),
    .rsp_valid(rv[1]), .rsp_err(re[1]), .rsp_rdata(rdat[1]), .ram_raddr(ra[1]),
    .ram_waddr(wa[1]), .ram_we(rwe[1]), .ram_din(din[1]), .ram_dout(dout[1]));

  // Physical RAMs with registered read, 1 and 2 cycle latency.
  logic [31:0] ram0 [1024];
  logic [31:0] ram1 [1024];
  logic [31:0] p0a, p1a, p1b;
  always @(posedge clk) begin
    if (rwe[0]) ram0[wa[0]] <= din[0];
    p0a <= ram0[ra[0]];
  end
  always @(posedge clk) begin
    if (rwe[1]) ram1[wa[1]] <= din[1];
    p1a <= ram1[ra[1]];
    p1b <= p1a;
  end
  assign dout[0] = p0a;
  assign dout[1] = p1b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int          total, bad, cyc;
  logic        pend  [2];
  int          due   [2];
  logic        e_err [2];
  logic        e_we  [2];
  logic [31:0] e_rd  [2];
  logic [31:0] e_din [2];
  logic [9:0]  e_wa  [2];
  logic [31:0] mmem  [2][1024];
  // What was seen at the last sample point.
  logic        acc_seen [2];
  logic        rsp_seen [2];
  logic [31:0] rsp_d    [2];
  logic        rsp_e    [2];
  logic [9:0]  rsp_wa   [2];
  logic [31:0] rsp_din  [2];
  logic        rdy_seen [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int k);
    logic [1:0]  off;
    int          sh;
    int          lat;
    logic [31:0] old, v, mask;
    lat = (k == 0) ? 1 : 2;
    // Reset kills any response that has not been produced yet.
    if (rst && pend[k] && (due[k] > cyc)) pend[k] = 1'b0;
    chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!rst && !pend[k]));
    rdy_seen[k] = rdy[k];
    acc_seen[k] = v_in[k] && rdy[k];
    rsp_seen[k] = rv[k];
    rsp_d[k]    = rdat[k];
    rsp_e[k]    = re[k];
    rsp_wa[k]   = wa[k];
    rsp_din[k]  = din[k];
    if (pend[k] && (due[k] == cyc)) begin
      chk($sformatf("rsp_valid%0d", k), 32'(rv[k]), 32'd1);
      chk($sformatf("rsp_err%0d", k), 32'(re[k]), 32'(e_err[k]));
      chk($sformatf("rsp_rdata%0d", k), rdat[k], e_rd[k]);
      chk($sformatf("ram_we%0d", k), 32'(rwe[k]), 32'(e_we[k]));
      if (e_we[k]) begin
        chk($sformatf("ram_waddr%0d", k), 32'(wa[k]), 32'(e_wa[k]));
        chk($sformatf("ram_din%0d", k), din[k], e_din[k]);
        mmem[k][e_wa[k]] = e_din[k];
      end
      pend[k] = 1'b0;
    end else begin
      chk($sformatf("idle_rsp_valid%0d", k), 32'(rv[k]), 32'd0);
      chk($sformatf("idle_ram_we%0d", k), 32'(rwe[k]), 32'd0);
    end
    if (acc_seen[k]) begin
      off  = addr[1:0];
      sh   = int'(off) * 8;
      old  = mmem[k][addr[11:2]];
      pend[k]  = 1'b1;
      e_wa[k]  = addr[11:2];
      e_rd[k]  = 32'd0;
      e_din[k] = 32'd0;
      e_we[k]  = 1'b0;
      e_err[k] = (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
      if (e_err[k]) begin
        due[k] = cyc + 1;
      end else if (we && size == 2'b10) begin
        due[k] = cyc + 1; e_we[k] = 1'b1; e_din[k] = wd;
      end else begin
        due[k] = cyc + 1 + lat;
        if (we) begin
          mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
          e_we[k]  = 1'b1;
          e_din[k] = (old & ~mask) | ((wd << sh) & mask);
        end else if (size == 2'b00) begin
          v = (old >> sh) & 32'h0000_00FF;
          if (!uns && v >= 32'd128) v = v - 32'd256;
          e_rd[k] = v;
        end else if (size == 2'b01) begin
          v = (old >> sh) & 32'h0000_FFFF;
          if (!uns && v >= 32'h0000_8000) v = v - 32'h0001_0000;
          e_rd[k] = v;
        end else begin
          e_rd[k] = old;
        end
      end
    end
  endtask

  // Sample both DUTs mid-cycle, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [11:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] d);
    we = w; addr = a; size = s; uns = u; wd = d;
  endtask

  task automatic do_req(input int k, input logic w, input logic [11:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output logic [9:0] owa, output logic [31:0] odin);
    int n;
    sel = k;
    set_req(w, a, s, u, d);
    vld = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_seen[k] && n < 20);
    if (!acc_seen[k]) chk("accept_timeout", 32'd0, 32'd1);
    vld = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!rsp_seen[k] && n < 20);
    if (!rsp_seen[k]) chk("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_d[k]; er = rsp_e[k]; owa = rsp_wa[k]; odin = rsp_din[k];
  endtask

  task automatic stream_req(input int i);
    case (i)
      0:       set_req(1'b1, 12'h020, 2'b10, 1'b0, 32'h1122_3344);
      1:       set_req(1'b0, 12'h023, 2'b00, 1'b0, 32'hFFFF_FFFF);
      2:       set_req(1'b1, 12'h022, 2'b01, 1'b0, 32'h0000_BEEF);
      default: set_req(1'b0, 12'h022, 2'b01, 1'b1, 32'h0000_0000);
    endcase
  endtask

  // Four back-to-back requests with valid held high.
  task automatic stream(input int k);
    int idx, nr, n;
    int acc_c [4];
    int rsp_c [4];
    logic [31:0] got [4];
    sel = k; idx = 0; nr = 0; n = 0;
    stream_req(0);
    vld = 1'b1;
    while (nr < 4 && n < 100) begin
      tick();
      n++;
      if (rsp_seen[k]) begin
        got[nr] = rsp_d[k]; rsp_c[nr] = cyc; nr++;
      end
      if (acc_seen[k]) begin
        acc_c[idx] = cyc; idx++;
        if (idx < 4) stream_req(idx);
        else vld = 1'b0;
      end
    end
    vld = 1'b0;
    chk($sformatf("stream_rsp_count%0d", k), 32'(nr), 32'd4);
    if (nr == 4) begin
      chk($sformatf("stream_lb%0d", k), got[1], 32'h0000_0011);
      chk($sformatf("stream_lhu%0d", k), got[3], 32'h0000_BEEF);
      chk($sformatf("stream_lat%0d", k), 32'(rsp_c[1] - acc_c[1]), 32'(k + 2));
    end
  endtask

  logic [31:0] rd, odin;
  logic        er;
  logic [9:0]  owa;

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; vld = 1'b0; sel = 0;
    set_req(1'b0, 12'h000, 2'b00, 1'b0, 32'd0);
    for (int i = 0; i < 1024; i++) begin
      ram0[i] = 32'd0; ram1[i] = 32'd0; mmem[0][i] = 32'd0; mmem[1][i] = 32'd0;
    end
    for (int k = 0; k < 2; k++) pend[k] = 1'b0;
    #1;
    repeat (3) tick();
    chk("reset_waddr", 32'(wa[0]), 32'd0);
    chk("reset_din", din[0], 32'd0);
    chk("reset_rdata", rdat[0], 32'd0);
    chk("reset_rsp_valid", 32'(rv[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Word store then word load.
    do_req(0, 1'b1, 12'h010, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er, owa, odin);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_waddr", 32'(owa), 32'd4);
    chk("sw_din", odin, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'd0, rd, er, owa, odin);
    chk("lw", rd, 32'hDEAD_BEEF);

    // Byte store and sub-word loads.
    do_req(0, 1'b1, 12'h011, 2'b00, 1'b0, 32'h0000_00AA, rd, er, owa, odin);
    chk("sb_din", odin, 32'hDEAD_AAEF);
    do_req(0, 1'b0, 12'h011, 2'b00, 1'b0, 32'd0, rd, er, owa, odin);
    chk("lb", rd, 32'hFFFF_FFAA);
    do_req(0, 1'b0, 12'h011, 2'b00, 1'b1, 32'd0, rd, er, owa, odin);
    chk("lbu", rd, 32'h0000_00AA);
    do_req(0, 1'b0, 12'h012, 2'b01, 1'b0, 32'd0, rd, er, owa, odin);
    chk("lh", rd, 32'hFFFF_DEAD);
    do_req(0, 1'b0, 12'h012, 2'b01, 1'b1, 32'd0, rd, er, owa, odin);
    chk("lhu", rd, 32'h0000_DEAD);

    // Error cases.
    do_req(0, 1'b0, 12'h013, 2'b10, 1'b0, 32'd0, rd, er, owa, odin);
    chk("err_lw", 32'(er), 32'd1);
    chk("err_lw_rdata", rd, 32'd0);
    do_req(0, 1'b1, 12'h015, 2'b01, 1'b0, 32'h0000_1234, rd, er, owa, odin);
    chk("err_sh", 32'(er), 32'd1);
    do_req(0, 1'b0, 12'h010, 2'b11, 1'b0, 32'd0, rd, er, owa, odin);
    chk("err_size", 32'(er), 32'd1);

    // Reset in the cycle after a byte store is accepted.
    sel = 0;
    set_req(1'b1, 12'h011, 2'b00, 1'b0, 32'h0000_0055);
    vld = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (acc_seen[0]) break;
    end
    vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(rdy_seen[0]), 32'd1);
    repeat (3) tick();
    do_req(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'd0, rd, er, owa, odin);
    chk("rst_readback", rd, 32'hDEAD_AAEF);

    // Back-to-back mixed requests, both read latencies.
    stream(0);
    stream(1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
